// File: rtl/oc8051_rom_fetch_pkg.sv
// oc8051_rom_fetch_pkg: shared types and constants for the ROM prefetch stage.
`timescale 1ns/1ps
package oc8051_rom_fetch_pkg;

   localparam int ROM_ADDR_W     = 16;
   localparam int ROM_DATA_W     = 8;
   localparam int DEFAULT_WINDOW = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RESP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/oc8051_rom_fetch_window.sv
// oc8051_rom_fetch_window: tagged byte window holding WINDOW consecutive ROM
// bytes starting at base. Computes the lookup offset and hit flags, loads
// bytes from the ROM, and offers a three-byte read port with write bypass.
// ROM_FETCH_PARTIAL_HIT_EN adds the partial-hit flag and the shift-down path.
`timescale 1ns/1ps
module oc8051_rom_fetch_window
   import oc8051_rom_fetch_pkg::*;
#(
   parameter int WINDOW = DEFAULT_WINDOW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ROM_ADDR_W-1:0] lookup_addr,
   output logic                  full_hit,
`ifdef ROM_FETCH_PARTIAL_HIT_EN
   output logic                  partial_hit,
   input  logic                  shift_en,
`endif
   output logic [3:0]            lookup_off,
   input  logic                  alloc,
   input  logic                  flush,
   input  logic                  set_valid,
   input  logic                  wr_en,
   input  logic [3:0]            wr_slot,
   input  logic [ROM_DATA_W-1:0] wr_data,
   input  logic [3:0]            rd_off,
   output logic [ROM_DATA_W-1:0] rd_data_0,
   output logic [ROM_DATA_W-1:0] rd_data_1,
   output logic [ROM_DATA_W-1:0] rd_data_2
);

   localparam logic [ROM_ADDR_W-1:0] FULL_MAX = ROM_ADDR_W'(WINDOW - 3);
`ifdef ROM_FETCH_PARTIAL_HIT_EN
   localparam logic [ROM_ADDR_W-1:0] WIN_LEN  = ROM_ADDR_W'(WINDOW);
`endif

   logic [ROM_ADDR_W-1:0] base_q;
   logic                  valid_q;
   logic [ROM_DATA_W-1:0] win_q [WINDOW];
   logic [ROM_ADDR_W-1:0] off;
   logic [ROM_DATA_W-1:0] rd_bytes [3];

   assign off        = lookup_addr - base_q;
   assign lookup_off = off[3:0];
   assign full_hit   = valid_q && (off <= FULL_MAX);
`ifdef ROM_FETCH_PARTIAL_HIT_EN
   assign partial_hit = valid_q && (off > FULL_MAX) && (off < WIN_LEN);
`endif

   // Tag and valid: a new allocation retags the window and marks it invalid
   // until the refill completes; flush always wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (alloc)
            base_q <= lookup_addr;
         if (flush)
            valid_q <= 1'b0;
         else if (set_valid)
            valid_q <= 1'b1;
         else if (alloc)
            valid_q <= 1'b0;
      end
   end

   // Byte storage: optional shift-down by the lookup offset, then ROM captures.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < WINDOW; i++)
            win_q[i] <= '0;
      end else begin
`ifdef ROM_FETCH_PARTIAL_HIT_EN
         if (shift_en)
            for (int i = 0; i < WINDOW; i++)
               for (int j = 0; j < WINDOW; j++)
                  if (j == i + int'(lookup_off))
                     win_q[i] <= win_q[j];
`endif
         if (wr_en)
            for (int j = 0; j < WINDOW; j++)
               if (wr_slot == 4'(j))
                  win_q[j] <= wr_data;
      end
   end

   // Three-byte read at rd_off, bypassing the byte being captured this cycle
   // so the final capture of a refill can go straight into the response.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rd_bytes[i] = '0;
         for (int j = 0; j < WINDOW; j++)
            if (j == int'(rd_off) + i)
               rd_bytes[i] = (wr_en && (wr_slot == 4'(j))) ? wr_data : win_q[j];
      end
   end

   assign rd_data_0 = rd_bytes[0];
   assign rd_data_1 = rd_bytes[1];
   assign rd_data_2 = rd_bytes[2];

endmodule

// File: rtl/oc8051_rom_fetch.sv
// oc8051_rom_fetch: instruction prefetch stage returning the three bytes at a
// requested address, served from a tagged window or refilled from a byte-wide
// synchronous ROM. Optional macro ROM_FETCH_PARTIAL_HIT_EN enables partial
// hits that shift the window and refill only the missing bytes.
`timescale 1ns/1ps
module oc8051_rom_fetch
   import oc8051_rom_fetch_pkg::*;
#(
   parameter int WINDOW = DEFAULT_WINDOW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ROM_ADDR_W-1:0] req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ROM_DATA_W-1:0] resp_data_0,
   output logic [ROM_DATA_W-1:0] resp_data_1,
   output logic [ROM_DATA_W-1:0] resp_data_2,
   input  logic                  flush,
   output logic                  rom_en,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [ROM_DATA_W-1:0] rom_data
);

   fetch_state_t state_q;
   logic [3:0]   issue_left_q;
   logic         cap_en_q;
   logic [3:0]   cap_slot_q;
   logic         flush_pend_q;

   logic                  accept;
   logic                  full_hit;
   logic                  hit;
   logic                  alloc;
   logic                  wr_en;
   logic                  last_cap;
   logic                  set_valid;
   logic [3:0]            lookup_off;
   logic [3:0]            rd_off;
   logic [ROM_DATA_W-1:0] rd_data_0;
   logic [ROM_DATA_W-1:0] rd_data_1;
   logic [ROM_DATA_W-1:0] rd_data_2;
`ifdef ROM_FETCH_PARTIAL_HIT_EN
   logic                  partial_hit;
   logic                  partial;
`endif

   assign req_ready = rst && (state_q == ST_IDLE) && (!resp_valid || resp_ready);
   assign accept    = req_valid && req_ready;
   assign hit       = full_hit && !flush;
`ifdef ROM_FETCH_PARTIAL_HIT_EN
   assign partial   = partial_hit && !flush;
`endif
   assign alloc     = accept && !hit;
   assign wr_en     = (state_q == ST_FETCH) && cap_en_q;
   assign last_cap  = wr_en && !rom_en;
   assign set_valid = last_cap && !flush_pend_q;
   assign rd_off    = (state_q == ST_IDLE) ? lookup_off : 4'd0;

   oc8051_rom_fetch_window #(
      .WINDOW      (WINDOW)
   ) u_window (
      .clk         (clk),
      .rst         (rst),
      .lookup_addr (req_addr),
      .full_hit    (full_hit),
`ifdef ROM_FETCH_PARTIAL_HIT_EN
      .partial_hit (partial_hit),
      .shift_en    (accept && partial),
`endif
      .lookup_off  (lookup_off),
      .alloc       (alloc),
      .flush       (flush),
      .set_valid   (set_valid),
      .wr_en       (wr_en),
      .wr_slot     (cap_slot_q),
      .wr_data     (rom_data),
      .rd_off      (rd_off),
      .rd_data_0   (rd_data_0),
      .rd_data_1   (rd_data_1),
      .rd_data_2   (rd_data_2)
   );

   // Control FSM: accepts requests, issues ROM strobes, tracks captures and
   // holds the registered response until the core consumes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         resp_valid   <= 1'b0;
         resp_data_0  <= '0;
         resp_data_1  <= '0;
         resp_data_2  <= '0;
         rom_en       <= 1'b0;
         rom_addr     <= '0;
         issue_left_q <= '0;
         cap_en_q     <= 1'b0;
         cap_slot_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (hit) begin
                     resp_data_0 <= rd_data_0;
                     resp_data_1 <= rd_data_1;
                     resp_data_2 <= rd_data_2;
                     resp_valid  <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     state_q      <= ST_FETCH;
                     rom_en       <= 1'b1;
                     cap_en_q     <= 1'b0;
                     flush_pend_q <= 1'b0;
`ifdef ROM_FETCH_PARTIAL_HIT_EN
                     if (partial) begin
                        rom_addr     <= req_addr + ROM_ADDR_W'(WINDOW) - {12'd0, lookup_off};
                        issue_left_q <= lookup_off - 4'd1;
                        cap_slot_q   <= 4'(WINDOW) - lookup_off;
                     end else
`endif
                     begin
                        rom_addr     <= req_addr;
                        issue_left_q <= 4'(WINDOW - 1);
                        cap_slot_q   <= '0;
                     end
                  end
               end
            end
            ST_FETCH: begin
               if (flush)
                  flush_pend_q <= 1'b1;
               cap_en_q <= rom_en;
               if (rom_en) begin
                  if (issue_left_q == 4'd0) begin
                     rom_en <= 1'b0;
                  end else begin
                     rom_addr     <= rom_addr + 16'd1;
                     issue_left_q <= issue_left_q - 4'd1;
                  end
               end
               if (wr_en)
                  cap_slot_q <= cap_slot_q + 4'd1;
               if (last_cap) begin
                  resp_data_0 <= rd_data_0;
                  resp_data_1 <= rd_data_1;
                  resp_data_2 <= rd_data_2;
                  resp_valid  <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
